// File: rtl/alu_seq_pkg.sv
// Shared types for alu_sequencer: request op codes, ALU control codes, FSM states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_ORR = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MOV = 4'd4,
    OP_CBZ = 4'd5,
    OP_MUL = 4'd6
  } alu_op_e;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_e;

  function automatic logic op_is_alu(input logic [3:0] op);
    return op <= OP_CBZ;
  endfunction

  function automatic logic [3:0] op_to_ctrl(input logic [3:0] op);
    logic [3:0] ctrl;
    case (op)
      OP_AND:         ctrl = ALU_AND;
      OP_ORR:         ctrl = ALU_ORR;
      OP_ADD:         ctrl = ALU_ADD;
      OP_SUB:         ctrl = ALU_SUB;
      OP_MOV, OP_CBZ: ctrl = ALU_PASSB;
      default:        ctrl = ALU_AND;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Request front end for the 64-bit ALU: one-op-at-a-time, result one edge after accept, held until rsp_ready.
// Define ALU_SEQ_MUL_EN for an iterative shift-add multiply reusing the ALU adder (up to 65 edges).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N    = 4,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [63:0]     req_a,
  input  logic [63:0]     req_b,
  input  logic [TAGW-1:0] req_tag,
  output logic [63:0]     alu_a,
  output logic [63:0]     alu_b,
  output logic [N-1:0]    alu_ctrl,
  input  logic [63:0]     alu_result,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [63:0]     rsp_result,
  output logic            rsp_zero,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_err
);

  state_e state;

`ifdef ALU_SEQ_MUL_EN
  logic [63:0] acc, mcand, mplier;
  logic [63:0] acc_nxt, mcand_nxt;

  // The ALU sees alu_a=acc, alu_b=mcand, ADD, so alu_result is acc+mcand this cycle.
  always_comb begin
    acc_nxt   = mplier[0] ? alu_result : acc;
    mcand_nxt = mcand << 1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
`ifdef ALU_SEQ_MUL_EN
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          rsp_tag   <= req_tag;
          rsp_err   <= 1'b0;
          req_ready <= 1'b0;
          if (op_is_alu(req_op)) begin
            alu_a    <= req_a;
            alu_b    <= req_b;
            alu_ctrl <= N'(op_to_ctrl(req_op));
            state    <= S_EXEC;
          end
`ifdef ALU_SEQ_MUL_EN
          else if (req_op == OP_MUL) begin
            acc      <= '0;
            mcand    <= req_a;
            mplier   <= req_b;
            alu_a    <= '0;
            alu_b    <= req_a;
            alu_ctrl <= N'(ALU_ADD);
            state    <= S_MUL;
          end
`endif
          else begin
            rsp_err    <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
          alu_a      <= '0;
          alu_b      <= '0;
          alu_ctrl   <= '0;
          state      <= S_RESP;
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: if (mplier == '0) begin
          rsp_result <= acc;
          rsp_zero   <= (acc == '0);
          rsp_valid  <= 1'b1;
          alu_a      <= '0;
          alu_b      <= '0;
          alu_ctrl   <= '0;
          state      <= S_RESP;
        end else begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier >> 1;
          alu_a  <= acc_nxt;
          alu_b  <= mcand_nxt;
        end
`endif
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          alu_a     <= '0;
          alu_b     <= '0;
          alu_ctrl  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed requests, an ALU stand-in, and a latency/result model checked every cycle.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int N    = 4;
  localparam int TAGW = 4;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [3:0]      req_op = 4'd0;
  logic [63:0]     req_a = 64'd0;
  logic [63:0]     req_b = 64'd0;
  logic [TAGW-1:0] req_tag = '0;
  logic [63:0]     alu_a, alu_b;
  logic [N-1:0]    alu_ctrl;
  logic [63:0]     alu_result;
  logic            alu_zero;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [63:0]     rsp_result;
  logic            rsp_zero;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // Combinational ALU that sits beside the sequencer in the real design.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = alu_b;
      default: alu_result = 64'd0;
    endcase
    alu_zero = (alu_result == 64'd0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'd5) || (op == 4'd6 && MUL_EN);
  endfunction

  function automatic logic [63:0] golden(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0:       return a & b;
      4'd1:       return a | b;
      4'd2:       return a + b;
      4'd3:       return a - b;
      4'd4, 4'd5: return b;
      4'd6:       return a * b;
      default:    return 64'd0;
    endcase
  endfunction

  function automatic logic [3:0] exp_ctrl(input logic [3:0] op);
    case (op)
      4'd0:       return 4'b0000;
      4'd1:       return 4'b0001;
      4'd2:       return 4'b0010;
      4'd3:       return 4'b0110;
      4'd4, 4'd5: return 4'b0111;
      default:    return 4'b0000;
    endcase
  endfunction

  // Edges from accept until the response appears.
  function automatic int exp_latency(input logic [3:0] op, input logic [63:0] b);
    int m;
    if (op != 4'd6) return 1;
    if (b == 64'd0) return 1;
    m = 0;
    for (int i = 0; i < 64; i++) if (b[i]) m = i;
    return m + 2;
  endfunction

  // Model: 0 idle, 1 single ALU op, 2 multiply, 3 response held.
  int              m_phase = 0;
  int              m_wait = 0;
  logic            m_valid = 1'b0;
  logic [63:0]     m_result = 64'd0;
  logic            m_zero = 1'b0;
  logic [TAGW-1:0] m_tag = '0;
  logic            m_err = 1'b0;
  logic [63:0]     m_pend = 64'd0;
  logic [63:0]     m_a = 64'd0;
  logic [63:0]     m_b = 64'd0;
  logic [3:0]      m_op = 4'd0;

  task automatic model_step();
    if (!reset) begin
      m_phase = 0; m_wait = 0; m_valid = 1'b0; m_result = 64'd0; m_zero = 1'b0;
      m_tag = '0; m_err = 1'b0; m_a = 64'd0; m_b = 64'd0; m_op = 4'd0;
    end else if (m_phase == 0) begin
      if (req_valid) begin
        m_tag = req_tag; m_a = req_a; m_b = req_b; m_op = req_op;
        if (is_legal(req_op)) begin
          m_err   = 1'b0;
          m_pend  = golden(req_op, req_a, req_b);
          m_wait  = exp_latency(req_op, req_b);
          m_phase = (req_op == 4'd6) ? 2 : 1;
        end else begin
          m_err = 1'b1; m_result = 64'd0; m_zero = 1'b0; m_valid = 1'b1; m_phase = 3;
        end
      end
    end else if (m_phase == 1 || m_phase == 2) begin
      m_wait--;
      if (m_wait == 0) begin
        m_result = m_pend; m_zero = (m_pend == 64'd0); m_valid = 1'b1; m_phase = 3;
      end
    end else if (rsp_ready) begin
      m_valid = 1'b0; m_phase = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(m_phase == 0));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_result", rsp_result, m_result);
    chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
    chk("rsp_tag", 64'(rsp_tag), 64'(m_tag));
    chk("rsp_err", 64'(rsp_err), 64'(m_err));
    if (m_phase != 2) begin
      chk("alu_a", alu_a, (m_phase == 1) ? m_a : 64'd0);
      chk("alu_b", alu_b, (m_phase == 1) ? m_b : 64'd0);
      chk("alu_ctrl", 64'(alu_ctrl), 64'((m_phase == 1) ? exp_ctrl(m_op) : 4'd0));
    end
  end

  task automatic accept(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAGW-1:0] t);
    int k = 0;
    while (!req_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    chk("send_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [TAGW-1:0] t, output int lat);
    accept(op, a, b, t);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("release_rsp_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    send(OP_ADD, 64'd5, 64'd7, 4'd3, lat);
    chk("add_lat", 64'(lat), 64'd1);
    chk("add_result", rsp_result, 64'd12);
    chk("add_zero", 64'(rsp_zero), 64'd0);
    chk("add_tag", 64'(rsp_tag), 64'd3);
    release_rsp();

    send(OP_SUB, 64'd9, 64'd9, 4'd1, lat);
    chk("sub_result", rsp_result, 64'd0);
    chk("sub_zero", 64'(rsp_zero), 64'd1);
    release_rsp();

    send(OP_CBZ, 64'd55, 64'd0, 4'd2, lat);
    chk("cbz0_zero", 64'(rsp_zero), 64'd1);
    release_rsp();
    send(OP_CBZ, 64'd55, 64'd1, 4'd2, lat);
    chk("cbz1_zero", 64'(rsp_zero), 64'd0);
    chk("cbz1_result", rsp_result, 64'd1);
    release_rsp();

    send(4'd15, 64'd1, 64'd2, 4'd6, lat);
    chk("ill_lat", 64'(lat), 64'd0);
    chk("ill_err", 64'(rsp_err), 64'd1);
    chk("ill_result", rsp_result, 64'd0);
    release_rsp();
    send(4'd7, 64'd1, 64'd2, 4'd8, lat);
    chk("ill7_err", 64'(rsp_err), 64'd1);
    release_rsp();

    send(OP_AND, 64'hF0F0, 64'hFF00, 4'd10, lat);
    chk("and_result", rsp_result, 64'hF000);
    chk("and_err_cleared", 64'(rsp_err), 64'd0);
    release_rsp();
    send(OP_MOV, 64'd1, 64'hABCD, 4'd11, lat);
    chk("mov_result", rsp_result, 64'hABCD);
    release_rsp();
    send(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd12, lat);
    chk("addwrap_result", rsp_result, 64'd0);
    chk("addwrap_zero", 64'(rsp_zero), 64'd1);
    release_rsp();

    send(OP_ORR, 64'hA0, 64'h05, 4'd7, lat);
    req_valid = 1'b1; req_op = OP_ADD; req_a = 64'd1; req_b = 64'd1; req_tag = 4'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_result", rsp_result, 64'hA5);
      chk("stall_tag", 64'(rsp_tag), 64'd7);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    release_rsp();

`ifdef ALU_SEQ_MUL_EN
    send(OP_MUL, 64'h1234, 64'h10, 4'd4, lat);
    chk("mul_lat", 64'(lat), 64'd6);
    chk("mul_result", rsp_result, 64'h12340);
    chk("mul_zero", 64'(rsp_zero), 64'd0);
    release_rsp();
    send(OP_MUL, 64'h1234, 64'd0, 4'd5, lat);
    chk("mul0_lat", 64'(lat), 64'd1);
    chk("mul0_result", rsp_result, 64'd0);
    chk("mul0_zero", 64'(rsp_zero), 64'd1);
    release_rsp();
    send(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 4'd6, lat);
    chk("mulneg_lat", 64'(lat), 64'd3);
    chk("mulneg_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFD);
    release_rsp();
    send(OP_MUL, 64'd3, 64'h8000_0000_0000_0000, 4'd9, lat);
    chk("mulmax_lat", 64'(lat), 64'd65);
    chk("mulmax_result", rsp_result, 64'h8000_0000_0000_0000);
    release_rsp();
`else
    send(OP_MUL, 64'd6, 64'd7, 4'd4, lat);
    chk("muldis_lat", 64'(lat), 64'd0);
    chk("muldis_err", 64'(rsp_err), 64'd1);
    chk("muldis_result", rsp_result, 64'd0);
    release_rsp();
`endif

    accept(OP_MUL, 64'd3, 64'h0000_0100_0000_0000, 4'd13);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_alu_a", alu_a, 64'd0);
    chk("midrst_alu_b", alu_b, 64'd0);
    chk("midrst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("midrst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("midrst_rsp_result", rsp_result, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("postrst_no_rsp", 64'(rsp_valid), 64'd0);
    send(OP_ADD, 64'd1, 64'd2, 4'd9, lat);
    chk("postrst_add_lat", 64'(lat), 64'd1);
    chk("postrst_add_result", rsp_result, 64'd3);
    chk("postrst_add_tag", 64'(rsp_tag), 64'd9);
    release_rsp();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
